// File: rtl/ddr_wr_burst_ctrl_if.sv
// AXI4 write-channel bundle between the burst controller and the DDR interconnect.
// Master drives AW/W/B-ready; slave answers with ready/valid/resp.
interface ddr_wr_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the write-path prefetch FIFO into AXI4 INCR bursts, one frame
// per buffer, rotating over NUM_BUF frame buffers.
module ddr_wr_burst_ctrl #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 230400,
  parameter int NUM_BUF     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic                  frame_start,
  output logic                  frame_done,
  output logic [1:0]            buf_idx,
  output logic                  err_bresp,
  output logic                  err_short,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  ddr_wr_burst_ctrl_if.master   axi
);

  localparam int WLW   = $clog2(FRAME_WORDS + 1);
  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            r_state;
  logic [WLW-1:0]        r_words_left;
  logic                  r_start_pend;
  logic                  r_started;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_awvalid;
  logic [8:0]            r_beats;
  logic [8:0]            r_beat_cnt;
  logic [1:0]            r_buf_idx;
  logic                  r_err_bresp;
  logic                  r_err_short;

  logic                  w_idle;
  logic                  w_addr;
  logic                  w_data;
  logic                  w_resp;
  logic                  w_apply;
  logic                  w_launch;
  logic [1:0]            w_next_idx;
  logic [ADDR_WIDTH-1:0] w_buf_base;
  logic [8:0]            w_beats_nx;
  logic                  w_wvalid;
  logic                  w_wlast;
  logic                  w_xfer;
  logic                  w_bacc;
  logic [WLW-1:0]        w_left_nx;

  assign w_idle = (r_state == S_IDLE);
  assign w_addr = (r_state == S_ADDR);
  assign w_data = (r_state == S_DATA);
  assign w_resp = (r_state == S_RESP);

  assign w_apply  = w_idle & r_start_pend;
  assign w_launch = w_idle & ~r_start_pend & cfg_en &
                    (r_words_left != '0) & fifo_rd_vld;

  // The very first start after reset lands on buffer 0, later ones rotate.
  assign w_next_idx = !r_started ? 2'd0 :
                      (r_buf_idx == 2'(NUM_BUF - 1)) ? 2'd0 :
                      r_buf_idx + 2'd1;
  assign w_buf_base = cfg_base +
                      cfg_stride * ADDR_WIDTH'(w_next_idx);

  assign w_beats_nx = (32'(r_words_left) < BURST_LEN) ?
                      9'(r_words_left) : 9'(BURST_LEN);

  assign w_wvalid  = w_data & fifo_rd_vld;
  assign w_wlast   = w_wvalid & (r_beat_cnt == r_beats - 9'd1);
  assign w_xfer    = w_wvalid & axi.wready;
  assign w_bacc    = w_resp & axi.bvalid;
  assign w_left_nx = r_words_left - WLW'(r_beats);

  assign axi.awaddr  = r_awaddr;
  assign axi.awlen   = r_awlen;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = fifo_rd_data;
  assign axi.wstrb   = '1;
  assign axi.wlast   = w_wlast;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_resp;

  assign fifo_rd_en = w_xfer;
  assign frame_done = w_bacc & (w_left_nx == '0);
  assign buf_idx    = r_buf_idx;
  assign err_bresp  = r_err_bresp;
  assign err_short  = r_err_short;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_start_pend <= 1'b0;
      r_started    <= 1'b0;
      r_addr       <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awvalid    <= 1'b0;
      r_beats      <= '0;
      r_beat_cnt   <= '0;
      r_buf_idx    <= '0;
      r_err_bresp  <= 1'b0;
      r_err_short  <= 1'b0;
    end else begin
      r_start_pend <= frame_start | (r_start_pend & ~w_apply);
      unique case (1'b1)
        w_idle: begin
          if (w_apply) begin
            r_err_short  <= r_err_short | (r_words_left != '0);
            r_buf_idx    <= w_next_idx;
            r_started    <= 1'b1;
            r_addr       <= w_buf_base;
            r_words_left <= WLW'(FRAME_WORDS);
          end else if (w_launch) begin
            r_beats   <= w_beats_nx;
            r_awaddr  <= r_addr;
            r_awlen   <= 8'(w_beats_nx - 9'd1);
            r_awvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        w_addr: begin
          if (axi.awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        w_data: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_wlast) r_state <= S_RESP;
          end
        end
        w_resp: begin
          if (axi.bvalid) begin
            r_err_bresp  <= r_err_bresp | (axi.bresp != 2'b00);
            r_addr       <= r_addr +
                            ADDR_WIDTH'(r_beats) * ADDR_WIDTH'(BYTES);
            r_words_left <= w_left_nx;
            r_state      <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Bench for ddr_wr_burst_ctrl: a frame-level reference model feeds a
// scoreboard while AXI/FIFO handshakes are randomised.
module tb_ddr_wr_burst_ctrl;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int BL = 16;
  localparam int FW = 40;
  localparam int NB = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } w_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    int            aw_p;
    int            w_p;
    int            b_p;
    int            f_p;
    logic [1:0]    exp_buf;
    logic [AW-1:0] exp_aw;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_stride;
  logic          frame_start;
  logic          frame_done;
  logic [1:0]    buf_idx;
  logic          err_bresp;
  logic          err_short;
  logic          fifo_rd_en;
  logic          fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data;

  ddr_wr_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  ddr_wr_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
    .FRAME_WORDS(FW), .NUM_BUF(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .frame_start(frame_start), .frame_done(frame_done),
    .buf_idx(buf_idx), .err_bresp(err_bresp), .err_short(err_short),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data), .axi(axi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] feed_q[$];
  aw_t           exp_aw_q[$];
  w_t            exp_w_q[$];
  bit            exp_b_q[$];

  int aw_p = 100, w_p = 100, b_p = 100, f_p = 100;
  int b_seen = 0, bad_b = -1;
  int fd_cnt = 0, w_beats = 0;
  bit outst = 0, w_open = 0, aw_hold = 0, aw_just = 0;
  bit first_pend = 0;
  logic [AW-1:0] first_aw = '0;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_len;

  int            m_idx = 0;
  bit            m_started = 0;
  int            m_left = 0;
  logic [AW-1:0] m_addr = '0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_start();
    m_idx     = m_started ? (m_idx + 1) % NB : 0;
    m_started = 1;
    m_addr    = cfg_base + AW'(m_idx) * cfg_stride;
    m_left    = FW;
  endtask

  task automatic model_burst();
    int  n;
    aw_t a;
    w_t  w;
    n = (m_left < BL) ? m_left : BL;
    a.addr = m_addr;
    a.len  = 8'(n - 1);
    exp_aw_q.push_back(a);
    for (int i = 0; i < n; i++) begin
      w.d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      w.last = (i == n - 1);
      exp_w_q.push_back(w);
      feed_q.push_back(w.d);
    end
    m_addr = m_addr + AW'(n * (DW / 8));
    m_left = m_left - n;
    exp_b_q.push_back(m_left == 0);
  endtask

  task automatic model_frame();
    model_start();
    while (m_left > 0) model_burst();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n && feed_q.size() > 0; i++)
      fifo_q.push_back(feed_q.pop_front());
  endtask

  task automatic step(input bit fs);
    aw_t a;
    w_t  w;
    @(negedge clk);
    frame_start = fs;
    axi.awready = ($urandom_range(99) < aw_p);
    axi.wready  = ($urandom_range(99) < w_p);
    axi.bvalid  = ($urandom_range(99) < b_p);
    axi.bresp   = (b_seen == bad_b) ? 2'b10 : 2'b00;
    if (fifo_q.size() > 0 && $urandom_range(99) < f_p) begin
      fifo_rd_vld  = 1'b1;
      fifo_rd_data = fifo_q[0];
    end else begin
      fifo_rd_vld  = 1'b0;
      fifo_rd_data = '0;
    end
    #1;
    if (aw_hold) begin
      chk("aw_addr_stable", axi.awaddr, hold_addr);
      chk("aw_len_stable", axi.awlen, hold_len);
    end
    if (aw_just) chk("awvalid_drop", axi.awvalid, 0);
    aw_just   = 0;
    aw_hold   = axi.awvalid && !axi.awready;
    hold_addr = axi.awaddr;
    hold_len  = axi.awlen;
    if (axi.awvalid && axi.awready) begin
      aw_just = 1;
      chk("aw_outstanding", outst, 0);
      outst  = 1;
      w_open = 1;
      if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        a = exp_aw_q.pop_front();
        chk("awaddr", axi.awaddr, a.addr);
        chk("awlen", axi.awlen, a.len);
      end
      if (first_pend) begin
        first_aw   = axi.awaddr;
        first_pend = 0;
      end
    end
    if (fifo_rd_en) begin
      chk("rd_en_needs_wready", axi.wready, 1);
      chk("rd_en_needs_beat", axi.wvalid && axi.wready, 1);
    end
    if (axi.wvalid) chk("wvalid_before_aw", w_open, 1);
    if (axi.wvalid && axi.wready) begin
      chk("pop_on_beat", fifo_rd_en, 1);
      chk("wstrb", axi.wstrb, 16'hFFFF);
      w_beats++;
      if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        w = exp_w_q.pop_front();
        chk("wdata", axi.wdata, w.d);
        chk("wlast", axi.wlast, w.last);
      end
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (axi.wlast) w_open = 0;
    end
    if (axi.bvalid && axi.bready) begin
      outst = 0;
      b_seen++;
      if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
      else chk("frame_done_on_b", frame_done, exp_b_q.pop_front());
    end else if (frame_done) begin
      chk("frame_done_stray", 1, 0);
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic run_until(input int target, input int budget);
    int c = 0;
    while (fd_cnt < target && c < budget) begin
      step(0);
      c++;
    end
    chk("frame_timeout", fd_cnt, target);
  endtask

  vec_t vt[5];

  initial begin
    int fd0, wb0, c;
    vt[0] = '{28'h1000, 28'h100000, 100, 100, 100, 100, 2'd0, 28'h1000};
    vt[1] = '{28'h1000, 28'h100000, 50, 60, 40, 70, 2'd1, 28'h101000};
    vt[2] = '{28'h1000, 28'h100000, 30, 80, 50, 50, 2'd2, 28'h201000};
    vt[3] = '{28'h1000, 28'h100000, 70, 40, 90, 80, 2'd0, 28'h1000};
    vt[4] = '{28'h2000, 28'h040000, 60, 60, 60, 60, 2'd1, 28'h42000};

    rst_n = 0; cfg_en = 1; cfg_base = 28'h1000; cfg_stride = 28'h100000;
    frame_start = 0; fifo_rd_vld = 0; fifo_rd_data = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_wlast", axi.wlast, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_bresp", err_bresp, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_awlen", axi.awlen, 0);
    chk("rst_buf_idx", buf_idx, 0);
    rst_n = 1;

    // table-driven frames: buffer rotation and randomised backpressure
    for (int v = 0; v < 5; v++) begin
      cfg_base = vt[v].base; cfg_stride = vt[v].stride;
      aw_p = vt[v].aw_p; w_p = vt[v].w_p;
      b_p = vt[v].b_p; f_p = vt[v].f_p;
      fd0 = fd_cnt; wb0 = w_beats;
      model_frame();
      feed(FW);
      first_pend = 1;
      step(1);
      run_until(fd0 + 1, 3000);
      repeat (5) step(0);
      chk("frame_done_once", fd_cnt, fd0 + 1);
      chk("frame_beats", w_beats - wb0, FW);
      chk("buf_idx", buf_idx, vt[v].exp_buf);
      chk("first_awaddr", first_aw, vt[v].exp_aw);
      chk("aw_drained", exp_aw_q.size(), 0);
      chk("err_short_clear", err_short, 0);
      chk("err_bresp_clear", err_bresp, 0);
    end

    // awready stalled for 10 cycles
    cfg_base = 28'h1000; cfg_stride = 28'h100000;
    aw_p = 0; w_p = 100; b_p = 100; f_p = 100;
    fd0 = fd_cnt;
    model_frame();
    feed(FW);
    step(1);
    c = 0;
    while (!axi.awvalid && c < 10) begin step(0); c++; end
    chk("aw_seen", axi.awvalid, 1);
    repeat (10) begin
      step(0);
      chk("awvalid_held", axi.awvalid, 1);
      chk("no_w_before_aw", axi.wvalid, 0);
    end
    aw_p = 100;
    run_until(fd0 + 1, 500);
    chk("buf_idx_stall", buf_idx, 2);

    // error response on the second burst of a frame
    fd0 = fd_cnt;
    bad_b = b_seen + 1;
    model_frame();
    feed(FW);
    step(1);
    run_until(fd0 + 1, 500);
    bad_b = -1;
    chk("err_bresp_set", err_bresp, 1);
    chk("buf_idx_bresp", buf_idx, 0);

    // frame_start arriving mid-burst after 20 words
    fd0 = fd_cnt; wb0 = w_beats;
    model_start();
    model_burst();
    model_burst();
    feed(20);
    step(1);
    c = 0;
    while (w_beats < wb0 + 20 && c < 200) begin step(0); c++; end
    chk("twenty_words", w_beats - wb0, 20);
    first_pend = 1;
    step(1);
    feed(12);
    model_frame();
    feed(FW);
    run_until(fd0 + 1, 1000);
    chk("err_short_set", err_short, 1);
    chk("err_bresp_sticky", err_bresp, 1);
    chk("buf_idx_short", buf_idx, 2);
    chk("short_next_base", first_aw, 28'h201000);
    chk("short_words", w_beats - wb0, 32 + FW);

    // cfg_en low holds off new bursts
    fd0 = fd_cnt;
    cfg_en = 0;
    model_frame();
    feed(FW);
    step(1);
    repeat (20) begin
      step(0);
      chk("cfg_en_blocks", axi.awvalid, 0);
    end
    cfg_en = 1;
    run_until(fd0 + 1, 500);
    chk("buf_idx_cfg", buf_idx, 0);

    // asynchronous reset in the middle of a data phase
    w_p = 50;
    model_frame();
    feed(FW);
    step(1);
    c = 0;
    while (!axi.wvalid && c < 50) begin step(0); c++; end
    chk("in_data", axi.wvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_wvalid", axi.wvalid, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    chk("arst_awaddr", axi.awaddr, 0);
    chk("arst_awlen", axi.awlen, 0);
    chk("arst_bready", axi.bready, 0);
    chk("arst_buf_idx", buf_idx, 0);
    chk("arst_err_bresp", err_bresp, 0);
    chk("arst_err_short", err_short, 0);
    repeat (3) begin
      @(negedge clk);
      fifo_rd_vld = 1; axi.wready = 1;
      #1;
      chk("arst_no_pop", fifo_rd_en, 0);
      chk("arst_no_aw", axi.awvalid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst_ctrl.md
Name: ddr_wr_burst_ctrl

Overview:
- Sequences the read side of the 128-bit write-path prefetch FIFO into AXI4 write bursts toward the DDR frame buffer.
- Runs entirely in the DDR/AXI clock domain, which is the FIFO read clock.
- Generates burst addresses within a selected frame buffer and splits each frame into fixed-length bursts plus a shorter tail burst.
- Rotates between NUM_BUF frame buffers and reports frame completion and errors.

Parameters:
- ADDR_WIDTH, 28: AXI byte-address width.
- DATA_WIDTH, 128: AXI data width; equals the FIFO read width.
- BURST_LEN, 16: maximum beats per burst, 1..256.
- FRAME_WORDS, 230400: DATA_WIDTH words per frame (1280x720x32 bit / 128).
- NUM_BUF, 3: number of frame buffers, 1..4.

Ports:
- clk  in  1  AXI/DDR clock; also the FIFO read clock.
- rst_n  in  1  asynchronous, active-low reset.
- Configuration and status:
  - cfg_en  in  1  enables burst generation.
  - cfg_base  in  ADDR_WIDTH  byte address of buffer 0; aligned to BURST_LEN*DATA_WIDTH/8.
  - cfg_stride  in  ADDR_WIDTH  byte distance between buffers.
  - frame_start  in  1  one-cycle pulse, already synchronised to clk.
  - frame_done  out  1  one-cycle pulse when the last B response of a frame is accepted.
  - buf_idx  out  2  buffer currently being written.
  - err_bresp  out  1  sticky; set by any BRESP not equal to OKAY.
  - err_short  out  1  sticky; set when a frame_start is applied while words_left is not 0.
- FIFO read side:
  - fifo_rd_en  out  1  FIFO read enable (pop).
  - fifo_rd_vld  in  1  FIFO read data valid.
  - fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- AXI write channels:
  - awaddr  out  ADDR_WIDTH
  - awlen  out  8
  - awvalid  out  1
  - awready  in  1
  - wdata  out  DATA_WIDTH
  - wstrb  out  DATA_WIDTH/8
  - wlast  out  1
  - wvalid  out  1
  - wready  in  1
  - bresp  in  2
  - bvalid  in  1
  - bready  out  1

Behaviour:
- Reset (rst_n low, asynchronous), all outputs as follows:
  - awvalid, wvalid, wlast, bready, fifo_rd_en, frame_done, err_bresp, err_short = 0.
  - awaddr = 0, awlen = 0, buf_idx = 0.
  - Internal: state = IDLE, words_left = 0, start_pend = 0.
- Constant outputs: awsize = log2(DATA_WIDTH/8), awburst = INCR, wstrb all ones. wstrb is a port; awsize and awburst are fixed by the interconnect wrapper.
- frame_start handling:
  - frame_start sets start_pend. It is applied only in IDLE; bursts are never aborted.
  - Apply: if words_left != 0, set err_short.
  - Apply, buffer select: buf_idx advances to buf_idx+1, wrapping from NUM_BUF-1 to 0. The first application after reset selects buffer 0.
  - Apply, counters: addr = cfg_base + buf_idx*cfg_stride (new buf_idx); words_left = FRAME_WORDS; clear start_pend.
- State machine:
  - IDLE: apply a pending start, which takes 1 cycle. Otherwise, if cfg_en=1, words_left != 0 and fifo_rd_vld=1, load beats = min(BURST_LEN, words_left), set awaddr = addr and awlen = beats-1, assert awvalid, and go to ADDR.
  - ADDR: hold awaddr, awlen and awvalid until awready=1. Deassert awvalid in the same handshake cycle and go to DATA.
  - DATA:
    - wvalid = fifo_rd_vld; wdata = fifo_rd_data (combinational passthrough, zero added latency).
    - fifo_rd_en = fifo_rd_vld & wready; a beat transfers when it is 1.
    - beat_cnt increments on each transfer.
    - wlast = wvalid & (beat_cnt == beats-1).
    - Transfer with wlast → go to RESP.
    - FIFO underflow mid-burst only deasserts wvalid; there is no timeout.
  - RESP: bready=1. On bvalid:
    - err_bresp |= (bresp != 0).
    - addr += beats*DATA_WIDTH/8.
    - words_left -= beats.
    - If words_left becomes 0, pulse frame_done.
    - Return to IDLE.
- Width and arithmetic rules:
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - words_left is ceil(log2(FRAME_WORDS+1)) bits wide.
- cfg_en and configuration changes:
  - cfg_en=0 blocks only new bursts; a burst already in progress completes.
  - cfg_base and cfg_stride are sampled only when a start is applied.
- Simultaneous events:
  - frame_start in the same cycle as the final bvalid: frame_done pulses, and the start is applied in the next IDLE cycle without setting err_short.
  - Multiple frame_start pulses before the start is applied collapse into one.
- Ordering: at most one outstanding burst; a new AW is never issued before the previous B response is accepted.

Test Plan:
- FRAME_WORDS=40, BURST_LEN=16, cfg_base=0x1000, FIFO pre-filled with 40 words, awready/wready/bvalid always 1:
  - awaddr 0x1000/0x1100/0x1200 with awlen 15/15/7.
  - wlast on beats 16, 32 and 40.
  - 40 FIFO pops; frame_done pulses once after the third B.
- Three frames with NUM_BUF=3 and cfg_stride=0x100000:
  - Buffers start at 0x1000, 0x101000 and 0x201000; buf_idx sequence 0,1,2.
  - A fourth frame_start returns to buf_idx 0.
- wready toggled 1-0-1 and fifo_rd_vld gapped mid-burst:
  - Each word sent exactly once, in order; fifo_rd_en never 1 while wready=0.
  - wdata matches the FIFO write sequence.
- awready held 0 for 10 cycles: awaddr and awlen stay stable, no W beats are issued, and awvalid drops the cycle after the handshake.
- frame_start after 20 of 40 words, mid-burst:
  - The current burst completes and err_short=1.
  - The next burst begins at the next buffer base with words_left=40.
- bresp=2'b10 on the second burst: err_bresp=1 and stays 1; the frame still completes and frame_done pulses.
- rst_n asserted low during DATA: all outputs return to their reset values asynchronously, with no further fifo_rd_en.
